// File: rtl/extensor_pipeline.sv
// Pipelined immediate extender: selects a field, sign/zero-extends it (or merges it
// under a latched high-order prefix) and queues the result in a small output FIFO.
module extensor_pipeline #(
    parameter int LARGURA_SAIDA = 32,
    parameter int LARGURA_1     = 17,
    parameter int LARGURA_2     = 22,
    parameter int LARGURA_IN    = 18,
    parameter int PROFUNDIDADE  = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [1:0]               selecao,
    input  logic                     sem_sinal,
    input  logic [LARGURA_1-1:0]     entrada_1,
    input  logic [LARGURA_2-1:0]     entrada_2,
    input  logic [LARGURA_IN-1:0]    entrada_in,
    input  logic                     entrada_valida,
    output logic                     entrada_pronta,
    output logic [LARGURA_SAIDA-1:0] saida,
    output logic                     saida_valida,
    input  logic                     saida_pronta,
    output logic                     prefixo_ativo
);

    localparam int PW = (PROFUNDIDADE > 1) ? $clog2(PROFUNDIDADE) : 1;
    localparam int CW = $clog2(PROFUNDIDADE + 1);
    localparam logic [CW-1:0] CHEIO  = CW'(PROFUNDIDADE);
    localparam logic [PW-1:0] ULTIMO = PW'(PROFUNDIDADE - 1);
    localparam int Z1 = LARGURA_SAIDA - LARGURA_1;
    localparam int Z2 = LARGURA_SAIDA - LARGURA_2;
    localparam int ZI = LARGURA_SAIDA - LARGURA_IN;

    logic [LARGURA_SAIDA-1:0] mem_q [PROFUNDIDADE];
    logic [PW-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]            count_q, count_d;
    logic [LARGURA_2-1:0]     prefixo_q, prefixo_d;
    logic                     ativo_q, ativo_d;
    logic                     aceita, carga, push, pop;
    logic [LARGURA_SAIDA-1:0] prefixo_largo, resultado;

    function automatic logic [PW-1:0] avanca(input logic [PW-1:0] p);
        return (p == ULTIMO) ? '0 : p + PW'(1);
    endfunction

    // Ready depends only on reset and occupancy, so a full FIFO refuses a push even during a pop.
    assign entrada_pronta = reset && (count_q < CHEIO);
    assign saida_valida   = (count_q != '0);
    assign saida          = saida_valida ? mem_q[rd_ptr_q] : '0;
    assign prefixo_ativo  = ativo_q;

    always_comb begin
        prefixo_largo = {{Z2{1'b0}}, prefixo_q};
        resultado     = '0;
        case (selecao)
            2'b00: resultado = ativo_q ? ((prefixo_largo << LARGURA_1) | {{Z1{1'b0}}, entrada_1})
                                       : {{Z1{~sem_sinal & entrada_1[LARGURA_1-1]}}, entrada_1};
            2'b01: resultado = ativo_q ? ((prefixo_largo << LARGURA_2) | {{Z2{1'b0}}, entrada_2})
                                       : {{Z2{~sem_sinal & entrada_2[LARGURA_2-1]}}, entrada_2};
            2'b10: resultado = ativo_q ? ((prefixo_largo << LARGURA_IN) | {{ZI{1'b0}}, entrada_in})
                                       : {{ZI{~sem_sinal & entrada_in[LARGURA_IN-1]}}, entrada_in};
            default: resultado = '0;
        endcase
    end

    always_comb begin
        aceita    = entrada_valida && entrada_pronta;
        carga     = aceita && (selecao == 2'b11);
        push      = aceita && (selecao != 2'b11);
        pop       = saida_valida && saida_pronta;
        wr_ptr_d  = push ? avanca(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d  = pop ? avanca(rd_ptr_q) : rd_ptr_q;
        count_d   = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        prefixo_d = carga ? entrada_2 : prefixo_q;
        ativo_d   = carga ? 1'b1 : (push ? 1'b0 : ativo_q);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            prefixo_q <= '0;
            ativo_q   <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            prefixo_q <= prefixo_d;
            ativo_q   <= ativo_d;
        end
    end

    // Storage needs no reset: entries are only visible while counted as occupied.
    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= resultado;
    end

endmodule

// File: tb/tb_extensor_pipeline.sv
// Bench for extensor_pipeline: directed steps plus random traffic checked every cycle
// against an arithmetic model holding the expected results in a queue.
module tb_extensor_pipeline;

    logic        clock;
    logic        reset;
    logic [1:0]  selecao;
    logic        sem_sinal;
    logic [16:0] entrada_1;
    logic [21:0] entrada_2;
    logic [17:0] entrada_in;
    logic        entrada_valida;
    logic        entrada_pronta;
    logic [31:0] saida;
    logic        saida_valida;
    logic        saida_pronta;
    logic        prefixo_ativo;

    extensor_pipeline dut (
        .clock          (clock),
        .reset          (reset),
        .selecao        (selecao),
        .sem_sinal      (sem_sinal),
        .entrada_1      (entrada_1),
        .entrada_2      (entrada_2),
        .entrada_in     (entrada_in),
        .entrada_valida (entrada_valida),
        .entrada_pronta (entrada_pronta),
        .saida          (saida),
        .saida_valida   (saida_valida),
        .saida_pronta   (saida_pronta),
        .prefixo_ativo  (prefixo_ativo)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [31:0] exp_q[$];
    logic [21:0] m_prefix;
    bit          m_active;
    bit          last_acc;
    int          total;
    int          bad;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Extension result from the arithmetic rules; w is the selected field width.
    function automatic logic [31:0] ref_ext(input int w, input logic [63:0] f, input bit uns,
                                            input bit act, input logic [21:0] pre);
        logic [63:0] r;
        if (act)                    r = ({42'b0, pre} << w) | f;
        else if (!uns && f[w-1])    r = f | (64'hFFFF_FFFF_FFFF_FFFF << w);
        else                        r = f;
        return r[31:0];
    endfunction

    // One clock cycle: drive, check outputs against the model, advance the model at the edge.
    task automatic step(input bit rst_n, input bit v, input logic [1:0] sel, input bit uns,
                        input logic [16:0] f1, input logic [21:0] f2, input logic [17:0] fin,
                        input bit rdy);
        bit          exp_pronta;
        bit          do_pop;
        logic [31:0] head;
        reset = rst_n; entrada_valida = v; selecao = sel; sem_sinal = uns;
        entrada_1 = f1; entrada_2 = f2; entrada_in = fin; saida_pronta = rdy;
        #1;
        exp_pronta = rst_n && (exp_q.size() < 2);
        head = (exp_q.size() > 0) ? exp_q[0] : 32'h0;
        chk("entrada_pronta", 32'(entrada_pronta), 32'(exp_pronta));
        chk("saida_valida", 32'(saida_valida), 32'(exp_q.size() > 0));
        chk("saida", saida, head);
        chk("prefixo_ativo", 32'(prefixo_ativo), 32'(m_active));
        last_acc = v && exp_pronta;
        do_pop = (exp_q.size() > 0) && rdy;
        @(posedge clock);
        if (!rst_n) begin
            exp_q.delete();
            m_prefix = '0;
            m_active = 0;
            last_acc = 0;
        end else begin
            if (do_pop) void'(exp_q.pop_front());
            if (last_acc) begin
                if (sel == 2'b11) begin
                    m_prefix = f2;
                    m_active = 1;
                end else begin
                    case (sel)
                        2'b00:   exp_q.push_back(ref_ext(17, 64'(f1), uns, m_active, m_prefix));
                        2'b01:   exp_q.push_back(ref_ext(22, 64'(f2), uns, m_active, m_prefix));
                        default: exp_q.push_back(ref_ext(18, 64'(fin), uns, m_active, m_prefix));
                    endcase
                    m_active = 0;
                end
            end
        end
        #1;
    endtask

    task automatic idle(input bit rdy);
        step(1, 0, 2'b00, 0, '0, '0, '0, rdy);
    endtask

    initial begin
        bit c_done;
        total = 0; bad = 0;
        reset = 0; entrada_valida = 0; selecao = 0; sem_sinal = 0;
        entrada_1 = 0; entrada_2 = 0; entrada_in = 0; saida_pronta = 0;
        m_prefix = 0; m_active = 0; last_acc = 0;
        @(posedge clock); #1;

        // Reset state
        step(0, 0, 2'b00, 0, '0, '0, '0, 0);
        step(0, 0, 2'b00, 0, '0, '0, '0, 0);
        chk("rst_saida", saida, 32'h0);
        chk("rst_valida", 32'(saida_valida), 32'h0);

        // Sign/zero extension of each field, one-cycle latency, then pop
        step(1, 1, 2'b00, 0, 17'h10000, '0, '0, 0);
        chk("sx_e1", saida, 32'hFFFF0000);
        chk("sx_e1_valida", 32'(saida_valida), 32'h1);
        idle(1);
        chk("pop_e1_valida", 32'(saida_valida), 32'h0);
        step(1, 1, 2'b00, 1, 17'h10000, '0, '0, 0);
        chk("zx_e1", saida, 32'h00010000);
        idle(1);
        step(1, 1, 2'b01, 0, '0, 22'h200000, '0, 0);
        chk("sx_e2", saida, 32'hFFE00000);
        idle(1);

        // Prefix load then merged constant
        step(1, 1, 2'b11, 0, '0, 22'h000ABC, '0, 0);
        chk("pfx_ativo", 32'(prefixo_ativo), 32'h1);
        chk("pfx_no_out", 32'(saida_valida), 32'h0);
        step(1, 1, 2'b10, 0, '0, '0, 18'h3FFFF, 0);
        chk("pfx_merge", saida, 32'h2AF3FFFF);
        chk("pfx_clear", 32'(prefixo_ativo), 32'h0);
        idle(1);

        // Backpressure: A, B fill the FIFO, C waits until a slot frees
        step(1, 1, 2'b00, 1, 17'h00123, '0, '0, 0);
        step(1, 1, 2'b01, 1, '0, 22'h012345, '0, 0);
        c_done = 0;
        for (int i = 0; i < 10 && !c_done; i++) begin
            step(1, 1, 2'b10, 1, '0, '0, 18'h2ABCD, i >= 2);
            c_done = last_acc;
        end
        chk("c_accepted_in_bound", 32'(c_done), 32'h1);
        repeat (3) idle(1);

        // Continuous push and pop at occupancy one
        step(1, 1, 2'b00, 0, 17'h1FFFF, '0, '0, 0);
        for (int i = 0; i < 8; i++)
            step(1, 1, 2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                 17'($urandom), 22'($urandom), 18'($urandom), 1);
        idle(1);

        // Random traffic including prefix loads and backpressure
        for (int i = 0; i < 300; i++)
            step(1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 17'($urandom), 22'($urandom), 18'($urandom), 1'($urandom_range(0, 1)));
        repeat (4) idle(1);

        // Mid-operation reset discards queue and pending prefix
        step(1, 1, 2'b11, 0, '0, 22'h000155, '0, 0);
        step(1, 1, 2'b00, 0, 17'h00007, '0, '0, 0);
        step(1, 1, 2'b11, 0, '0, 22'h000155, '0, 0);
        step(1, 1, 2'b10, 0, '0, '0, 18'h00009, 0);
        step(0, 0, 2'b00, 0, '0, '0, '0, 0);
        chk("mid_rst_valida", 32'(saida_valida), 32'h0);
        chk("mid_rst_ativo", 32'(prefixo_ativo), 32'h0);
        chk("mid_rst_saida", saida, 32'h0);
        step(1, 1, 2'b10, 0, '0, '0, 18'h00001, 0);
        chk("post_rst_no_pfx", saida, 32'h00000001);
        idle(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
